audio_pcm_out: RTL and testbench

- Downstream consumer of the CPU's per-channel sample writes (left/right strobes decoded from the sample-output addresses).
- Pairs left/right writes into stereo frames and buffers them in a FIFO.
- Releases one frame per FRAME_CLKS clocks as saturated 16-bit PCM for the DAC/testbench sink.
- Replaces the free-running underflow-credit counters with exact occupancy, underflow and overflow accounting.

---
 rtl/audio_out_pkg.sv | 30 +++
 rtl/sync_fifo.sv | 63 ++++++
 rtl/audio_pcm_out.sv | 199 +++++++++++++++++++
 tb/tb_audio_pcm_out.sv | 346 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/audio_out_pkg.sv
// Shared types and helpers for the PCM output path.
package audio_out_pkg;

    // One stereo frame as it sits in the FIFO and on the PCM outputs.
    typedef struct packed {
        logic [15:0] left;
        logic [15:0] right;
    } pcm_frame_t;

    typedef enum logic {
        PRIME = 1'b0,
        PLAY  = 1'b1
    } out_state_e;

    localparam int unsigned FRAME_W = $bits(pcm_frame_t);

    // Clamp a signed 32-bit sample into the signed 16-bit DAC range.
    function automatic logic [15:0] sat16(input logic signed [31:0] v);
        logic [15:0] r;
        if (v > 32'sd32767) begin
            r = 16'h7FFF;
        end else if (v < -32'sd32768) begin
            r = 16'h8000;
        end else begin
            r = v[15:0];
        end
        return r;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count. A pop and a push in the same cycle
// both take effect, so a full FIFO still accepts a push when it is also popped.
// A pop on an empty FIFO is ignored.
module sync_fifo #(
    parameter  int unsigned WIDTH = 32,
    parameter  int unsigned DEPTH = 64,
    localparam int unsigned AW    = $clog2(DEPTH),
    localparam int unsigned LW    = AW + 1
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [LW-1:0]    level
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [LW-1:0]    level_q;
    logic             do_push;
    logic             do_pop;

    assign empty   = (level_q == '0);
    assign full    = (level_q == LW'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign level   = level_q;
    assign rdata   = mem_q[rd_ptr_q];

    // Pointers and occupancy; reset empties the FIFO without touching storage.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   level_q <= level_q + LW'(1);
                2'b01:   level_q <= level_q - LW'(1);
                default: level_q <= level_q;
            endcase
        end
    end

    // Frame storage.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

endmodule

// File: rtl/audio_pcm_out.sv
// Stereo PCM output stage: pairs left/right sample writes into frames,
// buffers them, and releases one frame per FRAME_CLKS clocks.
//
// state | meaning
// PRIME | filling the FIFO, outputs held at 0, frame ticks ignored
// PLAY  | popping one frame per tick; an empty FIFO on a tick drops back to PRIME
module audio_pcm_out
    import audio_out_pkg::*;
#(
    parameter  int unsigned DEPTH      = 64,
    parameter  int unsigned FRAME_CLKS = 680,
    parameter  int unsigned PREFILL    = 16,
    localparam int unsigned LW         = $clog2(DEPTH) + 1,
    localparam int unsigned TW         = $clog2(FRAME_CLKS)
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          enable,
    input  logic [31:0]   sample_wdata,
    input  logic          sample_left_write,
    input  logic          sample_right_write,
    input  logic          clear_status,
    output logic [LW-1:0] fifo_level,
    output logic          fifo_full,
    output logic          playing,
    output logic [15:0]   pcm_left,
    output logic [15:0]   pcm_right,
    output logic          pcm_valid,
    output logic [31:0]   underflow_cnt,
    output logic [15:0]   overflow_cnt,
    output logic          pair_err
);

    out_state_e  state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic        tick;

    logic [31:0] left_hold_q, left_hold_d;
    logic        left_pending_q, left_pending_d;
    logic        pair_err_set;
    logic        push_req;
    pcm_frame_t  push_frame;

    logic        pop_req;
    logic [FRAME_W-1:0] fifo_rdata;
    logic        fifo_empty;
    logic        fifo_full_w;
    logic [LW-1:0] fifo_level_w;

    pcm_frame_t  pcm_q, pcm_d;
    logic        pcm_valid_q, pcm_valid_d;
    logic        underflow_inc;
    logic        overflow_inc;
    logic [31:0] underflow_q, underflow_d;
    logic [15:0] overflow_q, overflow_d;
    logic        pair_err_q, pair_err_d;

    sync_fifo #(
        .WIDTH (FRAME_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk    (clk),
        .resetn (resetn),
        .push   (push_req),
        .wdata  (push_frame),
        .pop    (pop_req),
        .rdata  (fifo_rdata),
        .full   (fifo_full_w),
        .empty  (fifo_empty),
        .level  (fifo_level_w)
    );

    // Left/right pairing. A right strobe always completes the pending left,
    // even when a left strobe arrives in the same cycle (that left is lost).
    always_comb begin
        left_hold_d       = left_hold_q;
        left_pending_d    = left_pending_q;
        pair_err_set      = 1'b0;
        push_req          = 1'b0;
        push_frame.left   = sat16(left_hold_q);
        push_frame.right  = sat16(sample_wdata);
        if (sample_right_write) begin
            if (left_pending_q) begin
                push_req       = 1'b1;
                left_pending_d = 1'b0;
            end else begin
                pair_err_set   = 1'b1;
            end
            if (sample_left_write) begin
                pair_err_set   = 1'b1;
            end
        end else if (sample_left_write) begin
            if (left_pending_q) begin
                pair_err_set   = 1'b1;
            end
            left_hold_d    = sample_wdata;
            left_pending_d = 1'b1;
        end
    end

    // Frame timer: 0..FRAME_CLKS-1 while enabled, tick on the last count.
    always_comb begin
        tick    = enable && (timer_q == TW'(FRAME_CLKS - 1));
        timer_d = timer_q + TW'(1);
        if (!enable || tick) begin
            timer_d = '0;
        end
    end

    // Playback FSM next-state and output frame selection.
    always_comb begin
        state_d       = state_q;
        pop_req       = 1'b0;
        pcm_d         = pcm_q;
        pcm_valid_d   = 1'b0;
        underflow_inc = 1'b0;
        case (state_q)
            PRIME: begin
                pcm_d = '0;
                if (fifo_level_w >= LW'(PREFILL)) begin
                    state_d = PLAY;
                end
            end
            PLAY: begin
                if (tick) begin
                    pcm_valid_d = 1'b1;
                    if (!fifo_empty) begin
                        pop_req = 1'b1;
                        pcm_d   = pcm_frame_t'(fifo_rdata);
                    end else begin
                        pcm_d         = '0;
                        underflow_inc = 1'b1;
                        state_d       = PRIME;
                    end
                end
            end
            default: state_d = PRIME;
        endcase
    end

    // Status counters; a clear in the same cycle as an increment wins.
    always_comb begin
        overflow_inc = push_req && fifo_full_w && !pop_req;
        underflow_d  = underflow_q + {31'd0, underflow_inc};
        overflow_d   = overflow_q;
        if (overflow_inc && (overflow_q != 16'hFFFF)) begin
            overflow_d = overflow_q + 16'd1;
        end
        pair_err_d   = pair_err_q | pair_err_set;
        if (clear_status) begin
            underflow_d = '0;
            overflow_d  = '0;
            pair_err_d  = 1'b0;
        end
    end

    // Pairing and timer registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            left_hold_q    <= '0;
            left_pending_q <= 1'b0;
            timer_q        <= '0;
        end else begin
            left_hold_q    <= left_hold_d;
            left_pending_q <= left_pending_d;
            timer_q        <= timer_d;
        end
    end

    // FSM state, output frame and status registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= PRIME;
            pcm_q       <= '0;
            pcm_valid_q <= 1'b0;
            underflow_q <= '0;
            overflow_q  <= '0;
            pair_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            pcm_q       <= pcm_d;
            pcm_valid_q <= pcm_valid_d;
            underflow_q <= underflow_d;
            overflow_q  <= overflow_d;
            pair_err_q  <= pair_err_d;
        end
    end

    assign fifo_level    = fifo_level_w;
    assign fifo_full     = fifo_full_w;
    assign playing       = (state_q == PLAY);
    assign pcm_left      = pcm_q.left;
    assign pcm_right     = pcm_q.right;
    assign pcm_valid     = pcm_valid_q;
    assign underflow_cnt = underflow_q;
    assign overflow_cnt  = overflow_q;
    assign pair_err      = pair_err_q;

endmodule

// File: tb/tb_audio_pcm_out.sv
// Self-checking bench for audio_pcm_out: saturation table, directed corner
// sequences and a randomized run against a queue-based reference model.
module tb_audio_pcm_out;

    localparam int DEPTH   = 4;
    localparam int FC      = 8;
    localparam int PREFILL = 2;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        enable = 1'b0;
    logic [31:0] sample_wdata = '0;
    logic        sample_left_write = 1'b0;
    logic        sample_right_write = 1'b0;
    logic        clear_status = 1'b0;
    logic [2:0]  fifo_level;
    logic        fifo_full;
    logic        playing;
    logic [15:0] pcm_left;
    logic [15:0] pcm_right;
    logic        pcm_valid;
    logic [31:0] underflow_cnt;
    logic [15:0] overflow_cnt;
    logic        pair_err;

    audio_pcm_out #(
        .DEPTH      (DEPTH),
        .FRAME_CLKS (FC),
        .PREFILL    (PREFILL)
    ) dut (
        .clk                (clk),
        .resetn             (resetn),
        .enable             (enable),
        .sample_wdata       (sample_wdata),
        .sample_left_write  (sample_left_write),
        .sample_right_write (sample_right_write),
        .clear_status       (clear_status),
        .fifo_level         (fifo_level),
        .fifo_full          (fifo_full),
        .playing            (playing),
        .pcm_left           (pcm_left),
        .pcm_right          (pcm_right),
        .pcm_valid          (pcm_valid),
        .underflow_cnt      (underflow_cnt),
        .overflow_cnt       (overflow_cnt),
        .pair_err           (pair_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    bit en_cur   = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [31:0] mq[$];
    bit          m_pend;
    logic [31:0] m_hold;
    bit          m_play;
    int          m_timer;
    logic [15:0] m_pl, m_pr;
    bit          m_valid;
    logic [31:0] m_und;
    logic [15:0] m_ovf;
    bit          m_perr;

    function automatic logic [15:0] ref_sat(input logic [31:0] v);
        int s;
        s = $signed(v);
        if (s > 32767) return 16'h7FFF;
        if (s < -32768) return 16'h8000;
        return v[15:0];
    endfunction

    task automatic model_reset();
        mq.delete();
        m_pend = 0; m_hold = '0; m_play = 0; m_timer = 0;
        m_pl = '0; m_pr = '0; m_valid = 0;
        m_und = '0; m_ovf = '0; m_perr = 0;
    endtask

    task automatic model_step(input bit l, input bit r, input bit en, input bit clr,
                              input logic [31:0] w);
        bit tick;
        int lvl0;
        logic [31:0] f;
        lvl0 = mq.size();
        tick = en && (m_timer == FC - 1);
        m_timer = (en && !tick) ? m_timer + 1 : 0;
        m_valid = 0;
        if (!m_play) begin
            m_pl = '0; m_pr = '0;
            if (lvl0 >= PREFILL) m_play = 1;
        end else if (tick) begin
            m_valid = 1;
            if (lvl0 > 0) begin
                f = mq.pop_front();
                m_pl = f[31:16]; m_pr = f[15:0];
            end else begin
                m_pl = '0; m_pr = '0;
                m_und = m_und + 1;
                m_play = 0;
            end
        end
        if (r) begin
            if (m_pend) begin
                m_pend = 0;
                if (mq.size() < DEPTH) mq.push_back({ref_sat(m_hold), ref_sat(w)});
                else if (m_ovf != 16'hFFFF) m_ovf = m_ovf + 1;
            end else begin
                m_perr = 1;
            end
            if (l) m_perr = 1;
        end else if (l) begin
            if (m_pend) m_perr = 1;
            m_hold = w;
            m_pend = 1;
        end
        if (clr) begin
            m_und = '0; m_ovf = '0; m_perr = 0;
        end
    endtask

    task automatic compare_all();
        check("level",     {29'd0, fifo_level}, 32'(mq.size()));
        check("full",      {31'd0, fifo_full},  {31'd0, mq.size() == DEPTH});
        check("playing",   {31'd0, playing},    {31'd0, m_play});
        check("pcm_left",  {16'd0, pcm_left},   {16'd0, m_pl});
        check("pcm_right", {16'd0, pcm_right},  {16'd0, m_pr});
        check("pcm_valid", {31'd0, pcm_valid},  {31'd0, m_valid});
        check("underflow", underflow_cnt,       m_und);
        check("overflow",  {16'd0, overflow_cnt}, {16'd0, m_ovf});
        check("pair_err",  {31'd0, pair_err},   {31'd0, m_perr});
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic step_cyc(input bit l, input bit r, input bit clr, input logic [31:0] w);
        sample_left_write  = l;
        sample_right_write = r;
        clear_status       = clr;
        sample_wdata       = w;
        enable             = en_cur;
        model_step(l, r, en_cur, clr, w);
        @(posedge clk);
        #1;
        sample_left_write  = 1'b0;
        sample_right_write = 1'b0;
        clear_status       = 1'b0;
        compare_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step_cyc(0, 0, 0, '0);
    endtask

    task automatic push_pair(input logic [31:0] l, input logic [31:0] r);
        step_cyc(1, 0, 0, l);
        step_cyc(0, 1, 0, r);
    endtask

    task automatic wait_valid(output int n, input int max);
        n = 0;
        for (int i = 0; i < max; i++) begin
            step_cyc(0, 0, 0, '0);
            n++;
            if (pcm_valid) return;
        end
        n_checks++;
        n_fail++;
        $display("FAIL wait_valid: no pcm_valid within %0d cycles, required a pulse (t=%0t)", max, $time);
    endtask

    task automatic do_reset();
        #2;
        resetn = 1'b0;
        model_reset();
        #1;
        check("rst_level",   {29'd0, fifo_level}, 32'd0);
        check("rst_pcm",     {pcm_left, pcm_right}, 32'd0);
        check("rst_playing", {31'd0, playing}, 32'd0);
        check("rst_status",  {15'd0, overflow_cnt, pair_err}, 32'd0);
        check("rst_underflow", underflow_cnt, 32'd0);
        compare_all();
        @(posedge clk);
        #1;
        resetn = 1'b1;
    endtask

    typedef struct {
        logic [31:0] l;
        logic [31:0] r;
        logic [15:0] el;
        logic [15:0] er;
    } vec_t;

    vec_t vecs[6];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int n;
        int und_before;

        vecs[0] = '{32'd100,        32'hFFFF_FF9C, 16'd100,   16'hFF9C};
        vecs[1] = '{32'd200,        32'hFFFF_FF38, 16'd200,   16'hFF38};
        vecs[2] = '{32'h0001_2345,  32'hFFFE_0000, 16'h7FFF,  16'h8000};
        vecs[3] = '{32'd32767,      32'hFFFF_8000, 16'h7FFF,  16'h8000};
        vecs[4] = '{32'd32768,      32'hFFFF_7FFF, 16'h7FFF,  16'h8000};
        vecs[5] = '{32'hFFFF_FFFF,  32'h7FFF_FFFF, 16'hFFFF,  16'h7FFF};

        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1;
        check("reset_level",   {29'd0, fifo_level}, 32'd0);
        check("reset_pcm",     {pcm_left, pcm_right}, 32'd0);
        check("reset_playing", {31'd0, playing}, 32'd0);
        compare_all();
        resetn = 1'b1;

        // Table: two frames per round, then a drained underflow tick.
        for (int k = 0; k < 6; k += 2) begin
            en_cur = 0;
            push_pair(vecs[k].l, vecs[k].r);
            push_pair(vecs[k+1].l, vecs[k+1].r);
            idle(1);
            check("prefill_play", {31'd0, playing}, 32'd1);
            en_cur = 1;
            wait_valid(n, 4 * FC);
            check("tab_left_a",  {16'd0, pcm_left},  {16'd0, vecs[k].el});
            check("tab_right_a", {16'd0, pcm_right}, {16'd0, vecs[k].er});
            wait_valid(n, 4 * FC);
            check("valid_spacing", n, FC);
            check("tab_left_b",  {16'd0, pcm_left},  {16'd0, vecs[k+1].el});
            check("tab_right_b", {16'd0, pcm_right}, {16'd0, vecs[k+1].er});
            wait_valid(n, 4 * FC);
            check("underflow_pcm", {pcm_left, pcm_right}, 32'd0);
            check("underflow_prime", {31'd0, playing}, 32'd0);
        end
        en_cur = 0;

        // Pairing violations.
        step_cyc(0, 0, 1, '0);
        step_cyc(1, 0, 0, 32'd5);
        step_cyc(1, 0, 0, 32'd7);
        check("pair_err_double_left", {31'd0, pair_err}, 32'd1);
        step_cyc(0, 1, 0, 32'd9);
        check("pair_level", {29'd0, fifo_level}, 32'd1);
        step_cyc(0, 0, 1, '0);
        check("pair_err_cleared", {31'd0, pair_err}, 32'd0);
        push_pair(32'd1, 32'd2);
        idle(1);
        en_cur = 1;
        wait_valid(n, 4 * FC);
        check("pair_frame", {pcm_left, pcm_right}, {16'd7, 16'd9});
        wait_valid(n, 4 * FC);
        wait_valid(n, 4 * FC);
        en_cur = 0;
        step_cyc(0, 1, 0, 32'd3);
        check("pair_err_lone_right", {31'd0, pair_err}, 32'd1);
        step_cyc(1, 0, 0, 32'd11);
        step_cyc(1, 1, 0, 32'd12);
        check("pair_both_level", {29'd0, fifo_level}, 32'd1);
        step_cyc(0, 1, 0, 32'd13);
        check("pair_both_discard", {29'd0, fifo_level}, 32'd1);

        // Overflow and drain into underflow.
        do_reset();
        en_cur = 0;
        for (int i = 0; i < 6; i++) push_pair(32'(10 * (i + 1)), 32'(20 * (i + 1)));
        check("ovf_full",  {31'd0, fifo_full}, 32'd1);
        check("ovf_level", {29'd0, fifo_level}, 32'd4);
        check("ovf_count", {16'd0, overflow_cnt}, 32'd2);
        en_cur = 1;
        wait_valid(n, 4 * FC);
        check("ovf_first", {pcm_left, pcm_right}, {16'd10, 16'd20});
        wait_valid(n, 4 * FC);
        wait_valid(n, 4 * FC);
        wait_valid(n, 4 * FC);
        check("ovf_last", {pcm_left, pcm_right}, {16'd40, 16'd80});
        wait_valid(n, 4 * FC);
        check("drain_pcm", {pcm_left, pcm_right}, 32'd0);
        check("drain_underflow", underflow_cnt, 32'd1);
        check("drain_prime", {31'd0, playing}, 32'd0);

        // Level 1 in PLAY with a push landing on the tick.
        en_cur = 0;
        push_pair(32'h111, 32'h222);
        push_pair(32'h333, 32'h444);
        idle(1);
        en_cur = 1;
        wait_valid(n, 4 * FC);
        check("l1_first", {pcm_left, pcm_right}, {16'h111, 16'h222});
        check("l1_level", {29'd0, fifo_level}, 32'd1);
        und_before = underflow_cnt;
        step_cyc(1, 0, 0, 32'h555);
        for (int i = 0; i < 2 * FC && m_timer != FC - 1; i++) idle(1);
        step_cyc(0, 1, 0, 32'h666);
        check("l1_valid", {31'd0, pcm_valid}, 32'd1);
        check("l1_old_frame", {pcm_left, pcm_right}, {16'h333, 16'h444});
        check("l1_level_kept", {29'd0, fifo_level}, 32'd1);
        check("l1_no_underflow", underflow_cnt, 32'(und_before));
        check("l1_playing", {31'd0, playing}, 32'd1);

        // Asynchronous reset mid-frame with frames buffered.
        en_cur = 0;
        push_pair(32'h777, 32'h888);
        push_pair(32'h999, 32'hAAA);
        en_cur = 1;
        idle(3);
        check("rst3_level", {29'd0, fifo_level}, 32'd3);
        do_reset();
        push_pair(32'h10, 32'h20);
        check("post_rst_level", {29'd0, fifo_level}, 32'd1);
        check("post_rst_prime", {31'd0, playing}, 32'd0);

        // Randomized run against the model.
        for (int i = 0; i < 3000; i++) begin
            bit l, r, clr;
            logic [31:0] w;
            if ($urandom_range(0, 99) < 3) en_cur = ~en_cur;
            l   = ($urandom_range(0, 99) < 15);
            r   = ($urandom_range(0, 99) < 15);
            clr = ($urandom_range(0, 99) < 1);
            if ($urandom_range(0, 3) == 0) w = $urandom();
            else w = 32'($urandom_range(0, 80000)) - 32'd40000;
            step_cyc(l, r, clr, w);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
